seg7_reader: RTL and testbench
==============================

# seg7_reader

Receive-side counterpart of the 7-segment digit decoder. It observes a multiplexed multi-digit display bus (one-hot digit select plus 7 segment lines), waits for each digit to be stable, and maps each segment pattern back to its 4-bit digit value. Complete frames are presented on a valid/ready output. It sits in display self-test and loopback paths, fed directly by the display scan driver outputs.

## Interface
- `DIGITS`, default 4: number of multiplexed digits; legal values are 1 to 8.
- `STABLE_CYCLES`, default 4: number of consecutive identical samples required before a digit is captured; minimum 2.
- `clk`, in, 1: the single clock; all state changes on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `seg_in`, in, 7: segment lines, active-high. Bit 0 is segment a and bit 6 is segment g.
- `dig_sel`, in, `DIGITS`: one-hot digit enable, active-high. Bit i selects digit i.
- `frame_data`, out, 4*`DIGITS`: decoded digits, with digit i in bits [4i+3:4i].
- `frame_err`, out, `DIGITS`: bit i is set when digit i's pattern was not recognised.
- `frame_valid`, out, 1: a captured frame is available on the outputs.
- `frame_ready`, in, 1: the consumer accepts the frame.
- `overrun`, out, 1: one-cycle pulse when a completed frame is discarded.

## Operation
- **Sample stage.** `seg_in` and `dig_sel` are registered every cycle into sample registers.
- **FSM states:**
  - IDLE: the sampled `dig_sel` is zero or not one-hot, and the stability counter is 0.
  - TRACK: counting consecutive identical samples.
  - HELD: the digit has been captured; the FSM waits for the select or the segments to change.
- **FSM transitions:**
  - IDLE to TRACK when the sampled select is one-hot; the counter is set to 1.
  - In TRACK, if the sample equals the previous sample, the counter increments. When it reaches `STABLE_CYCLES`, the digit is captured and the FSM goes to HELD.
  - In TRACK, a differing sample that is one-hot restarts the counter at 1; a non-one-hot sample goes to IDLE.
  - HELD to TRACK on any change to a one-hot value, or HELD to IDLE on a non-one-hot value. A steady input never captures twice.
- **Capture:**
  - The decoded code and error flag are written into the working slot for the selected digit.
  - The digit's bit in the capture mask is set.
  - Re-capturing a digit before the frame completes overwrites that slot.
- **Pattern map** (segments g..a, digit value):
  - 0111111 = 0, 0000110 = 1, 1011011 = 2, 1001111 = 3, 1100110 = 4
  - 1101101 = 5, 1111101 = 6, 0000111 = 7, 1111111 = 8, 1101111 = 9
  - 0000000 (blank) decodes to 4'hF with the error flag clear.
  - Any other pattern decodes to 4'hE with the error flag set.
- **Frame complete** when the capture mask is all ones, including the capture happening in the current cycle. On the next edge the mask clears to zero. Then:
  - If `frame_valid` is 0, or `frame_valid` and `frame_ready` are both 1 in that cycle, the working slots are copied to `frame_data`/`frame_err` and `frame_valid` is 1.
  - Otherwise the frame is dropped, `overrun` pulses for one cycle, and the output registers are unchanged.
- **Handshake:**
  - `frame_valid` stays high and `frame_data` stays stable until a cycle with `frame_ready` = 1. On that edge `frame_valid` clears, unless a new frame loads on the same edge.
  - `frame_ready` while `frame_valid` = 0 has no effect.
- **Reset values:** `frame_data` all zeros, `frame_err` all zeros, `frame_valid` 0, `overrun` 0. Internally the FSM is in IDLE, the counter is 0, the capture mask is 0, and the working slots are zero.
- **Reset mid-frame:** all partial captures are discarded.

## Timing
- Capture latency: with input first present before edge k and held, the digit is captured at edge k+`STABLE_CYCLES`.
- Frame latency: `frame_valid` rises at edge k+`STABLE_CYCLES`+1, where k belongs to the final digit of the frame.
- Glitch rejection: a select or segment value held for fewer than `STABLE_CYCLES` samples is never captured.
- Output path: all outputs are registered, with no combinational path from inputs to outputs.

## Configuration
- Macro `SEG7_READER_SYNC_EN`.
- When defined, `seg_in` and `dig_sel` pass through a two-flop synchronizer (reset to 0) ahead of the sample stage. This is for inputs that are asynchronous to `clk` and adds exactly 2 cycles to every latency above.
- When undefined, the inputs are treated as synchronous to `clk`, with no extra latency.

## Structure
- **Shared package `seg7_pkg`:**
  - the ten pattern constants `SEG_0`..`SEG_9` and `SEG_BLANK`
  - codes `CODE_BLANK` = 4'hF and `CODE_INVALID` = 4'hE
  - the FSM state type (IDLE, TRACK, HELD)
- **Sub-module `seg7_pattern_decode`:** purely combinational, 7-bit pattern in, 4-bit code plus error flag out. It is reusable by the display test bench.

## Test plan
- **Full frame:** `DIGITS`=4, `STABLE_CYCLES`=4; drive digits 0..3 with patterns for 1, 2, 3, 4, holding each for 6 cycles, with `frame_ready`=1. Expect `frame_data`=16'h4321, `frame_err`=0, and `frame_valid` high for 1 cycle, at edge k+5 after the last digit is presented.
- **Glitch rejection:** select digit 2 for 3 cycles only, then complete the frame normally. Expect digit 2 to hold its earlier captured value and no capture from the 3-cycle pulse.
- **Invalid and blank patterns:** drive digit 1 with 0000001 and digit 3 with 0000000. Expect nibble 1 = 4'hE, nibble 3 = 4'hF, and `frame_err`=4'b0010.
- **Backpressure:** hold `frame_ready`=0 through two complete frames. Expect the first frame held stable, one `overrun` pulse for the second, and the first frame consumed when ready rises.
- **Reset mid-frame:** assert `rst` after 2 digits are captured, then drive one full frame. Expect exactly one `frame_valid` carrying only the post-reset values, and all outputs zero during reset.
- **Synchronizer build:** with `SEG7_READER_SYNC_EN` defined, repeat the full-frame test. Expect `frame_valid` exactly 2 cycles later than in the first test.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared definitions for the seven-segment display reader.
// Holds the segment patterns (bit 0 = segment a, bit 6 = segment g),
// the special codes returned for blank and unrecognised patterns, and
// the per-digit stability FSM state type.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  localparam logic [3:0] CODE_BLANK   = 4'hF;
  localparam logic [3:0] CODE_INVALID = 4'hE;

  // IDLE : no valid one-hot select sampled
  // TRACK: counting consecutive identical samples
  // HELD : digit captured, waiting for the input to change
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    HELD  = 2'd2
  } seg7_state_e;

endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: purely combinational map from a 7-segment pattern
// back to its digit value.
//   i_pattern : segment lines, bit 0 = a ... bit 6 = g
//   o_code    : 0..9 for digit patterns, CODE_BLANK for all-off,
//               CODE_INVALID for anything else
//   o_err     : set only for unrecognised patterns (blank is not an error)
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_code,
  output logic       o_err
);

  // Pattern lookup; every unlisted pattern falls to the invalid code.
  always_comb begin
    o_code = CODE_INVALID;
    o_err  = 1'b1;
    case (i_pattern)
      SEG_0:     begin o_code = 4'd0;       o_err = 1'b0; end
      SEG_1:     begin o_code = 4'd1;       o_err = 1'b0; end
      SEG_2:     begin o_code = 4'd2;       o_err = 1'b0; end
      SEG_3:     begin o_code = 4'd3;       o_err = 1'b0; end
      SEG_4:     begin o_code = 4'd4;       o_err = 1'b0; end
      SEG_5:     begin o_code = 4'd5;       o_err = 1'b0; end
      SEG_6:     begin o_code = 4'd6;       o_err = 1'b0; end
      SEG_7:     begin o_code = 4'd7;       o_err = 1'b0; end
      SEG_8:     begin o_code = 4'd8;       o_err = 1'b0; end
      SEG_9:     begin o_code = 4'd9;       o_err = 1'b0; end
      SEG_BLANK: begin o_code = CODE_BLANK; o_err = 1'b0; end
      default:   begin o_code = CODE_INVALID; o_err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_reader.sv
// seg7_reader: observes a multiplexed 7-segment display bus, waits for
// each selected digit to be stable for STABLE_CYCLES samples, decodes it
// and assembles complete frames presented on a valid/ready interface.
//
// Parameters:
//   DIGITS        number of multiplexed digits (1..8)
//   STABLE_CYCLES identical samples required before capture (>= 2)
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   seg_in       segment lines (bit 0 = a, bit 6 = g)
//   dig_sel      one-hot digit select
//   frame_data   decoded digits, digit i in [4i+3:4i]
//   frame_err    per-digit unrecognised-pattern flags
//   frame_valid  frame available; held until frame_ready
//   frame_ready  consumer accepts the frame
//   overrun      one-cycle pulse when a completed frame is dropped
//
// Build option: define SEG7_READER_SYNC_EN to put a two-flop synchronizer
// on seg_in/dig_sel ahead of the sample stage (adds 2 cycles latency).
module seg7_reader
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_in,
  input  logic [DIGITS-1:0]     dig_sel,
  output logic [4*DIGITS-1:0]   frame_data,
  output logic [DIGITS-1:0]     frame_err,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [6:0]          w_seg_src;
  logic [DIGITS-1:0]   w_sel_src;

`ifdef SEG7_READER_SYNC_EN
  logic [6:0]          r_seg_meta;
  logic [6:0]          r_seg_sync;
  logic [DIGITS-1:0]   r_sel_meta;
  logic [DIGITS-1:0]   r_sel_sync;

  // Two-flop synchronizer for display lines asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_meta <= 7'd0;
      r_seg_sync <= 7'd0;
      r_sel_meta <= {DIGITS{1'b0}};
      r_sel_sync <= {DIGITS{1'b0}};
    end else begin
      r_seg_meta <= seg_in;
      r_seg_sync <= r_seg_meta;
      r_sel_meta <= dig_sel;
      r_sel_sync <= r_sel_meta;
    end
  end

  assign w_seg_src = r_seg_sync;
  assign w_sel_src = r_sel_sync;
`else
  assign w_seg_src = seg_in;
  assign w_sel_src = dig_sel;
`endif

  logic [6:0]          r_seg_smp;
  logic [DIGITS-1:0]   r_sel_smp;
  logic [6:0]          r_seg_prev;
  logic [DIGITS-1:0]   r_sel_prev;

  // Sample stage plus a one-cycle-older copy used for the equality test.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_smp  <= 7'd0;
      r_sel_smp  <= {DIGITS{1'b0}};
      r_seg_prev <= 7'd0;
      r_sel_prev <= {DIGITS{1'b0}};
    end else begin
      r_seg_smp  <= w_seg_src;
      r_sel_smp  <= w_sel_src;
      r_seg_prev <= r_seg_smp;
      r_sel_prev <= r_sel_smp;
    end
  end

  logic w_onehot;
  logic w_same;

  // x & (x-1) clears the lowest set bit; zero result with x != 0 means one-hot.
  assign w_onehot = (r_sel_smp != {DIGITS{1'b0}}) &&
                    ((r_sel_smp & (r_sel_smp - DIGITS'(1))) == {DIGITS{1'b0}});
  assign w_same   = (r_sel_smp == r_sel_prev) && (r_seg_smp == r_seg_prev);

  seg7_state_e       r_state;
  seg7_state_e       w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_capture;

  // Stability FSM state and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state logic. The counter holds how many identical samples of the
  // current value have been seen; capture fires on the one that reaches
  // STABLE_CYCLES, after which HELD suppresses any repeat capture.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_capture   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_onehot) begin
          w_state_nxt = TRACK;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end
      end
      TRACK: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (!w_same) begin
          w_state_nxt = TRACK;
          w_cnt_nxt   = CNT_W'(1);
        end else if (r_cnt == CNT_W'(STABLE_CYCLES - 1)) begin
          w_state_nxt = HELD;
          w_cnt_nxt   = CNT_W'(STABLE_CYCLES);
          w_capture   = 1'b1;
        end else begin
          w_state_nxt = TRACK;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (!w_onehot) begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = {CNT_W{1'b0}};
        end else if (!w_same) begin
          w_state_nxt = TRACK;
          w_cnt_nxt   = CNT_W'(1);
        end else begin
          w_state_nxt = HELD;
          w_cnt_nxt   = r_cnt;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  logic [3:0] w_code;
  logic       w_err;

  seg7_pattern_decode u_decode (
    .i_pattern (r_seg_smp),
    .o_code    (w_code),
    .o_err     (w_err)
  );

  logic [DIGITS-1:0]   w_cap_bits;
  logic                w_frame_done;
  logic [DIGITS-1:0]   r_mask;
  logic [4*DIGITS-1:0] r_work_data;
  logic [DIGITS-1:0]   r_work_err;
  logic                r_done;

  // The capture in flight counts toward completion in the same cycle.
  assign w_cap_bits   = w_capture ? r_sel_smp : {DIGITS{1'b0}};
  assign w_frame_done = w_capture && ((r_mask | w_cap_bits) == {DIGITS{1'b1}});

  // Working slots and capture mask; the mask restarts once a frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask      <= {DIGITS{1'b0}};
      r_work_data <= {(4*DIGITS){1'b0}};
      r_work_err  <= {DIGITS{1'b0}};
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (w_cap_bits[i]) begin
          r_work_data[4*i +: 4] <= w_code;
          r_work_err[i]         <= w_err;
        end
      end
      if (w_frame_done) begin
        r_mask <= {DIGITS{1'b0}};
      end else begin
        r_mask <= r_mask | w_cap_bits;
      end
    end
  end

  // Completion flag, delayed one cycle so the slots already hold the final digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_frame_done;
    end
  end

  logic [4*DIGITS-1:0] r_frame_data;
  logic [DIGITS-1:0]   r_frame_err;
  logic                r_frame_valid;
  logic                r_overrun;

  // Output frame register with valid/ready handshake and overrun detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_frame_data  <= {(4*DIGITS){1'b0}};
      r_frame_err   <= {DIGITS{1'b0}};
      r_frame_valid <= 1'b0;
      r_overrun     <= 1'b0;
    end else if (r_done) begin
      if (!r_frame_valid || frame_ready) begin
        r_frame_data  <= r_work_data;
        r_frame_err   <= r_work_err;
        r_frame_valid <= 1'b1;
        r_overrun     <= 1'b0;
      end else begin
        r_overrun     <= 1'b1;
      end
    end else begin
      r_overrun <= 1'b0;
      if (r_frame_valid && frame_ready) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign frame_data  = r_frame_data;
  assign frame_err   = r_frame_err;
  assign frame_valid = r_frame_valid;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_seg7_reader.sv
// Self-checking bench for seg7_reader (DIGITS=4, STABLE_CYCLES=4).
// A run-length reference model predicts every output each cycle; directed
// scenarios add hand-computed frame values and latency checks, followed by
// randomized display traffic with random backpressure.
module tb_seg7_reader;

  localparam int D = 4;
  localparam int S = 4;
`ifdef SEG7_READER_SYNC_EN
  localparam int LAT = S + 3;
`else
  localparam int LAT = S + 1;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [6:0]     seg_in = 7'd0;
  logic [D-1:0]   dig_sel = '0;
  logic [4*D-1:0] frame_data;
  logic [D-1:0]   frame_err;
  logic           frame_valid;
  logic           frame_ready = 1'b1;
  logic           overrun;

  seg7_reader #(.DIGITS(D), .STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_in      (seg_in),
    .dig_sel     (dig_sel),
    .frame_data  (frame_data),
    .frame_err   (frame_err),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void decode(input logic [6:0] p, output logic [3:0] c, output logic e);
    c = 4'hE;
    e = 1'b1;
    if (p == 7'h00) begin
      c = 4'hF;
      e = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (pats[i] == p) begin
        c = 4'(i);
        e = 1'b0;
      end
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  logic [4*D-1:0] exp_data;
  logic [D-1:0]   exp_err;
  logic           exp_valid, exp_overrun;
  logic [3:0]     slot_code [D];
  logic           slot_err  [D];
  logic [D-1:0]   m_mask;
  logic           done_pend, cap_pend;
  int             cap_idx;
  logic [3:0]     cap_code;
  logic           cap_err;
  logic [D-1:0]   run_sel, m_xs, s1_sel, s2_sel;
  logic [6:0]     run_seg, m_xg, s1_seg, s2_seg;
  int             run_len;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_data = '0; exp_err = '0; exp_valid = 0; exp_overrun = 0;
      for (int i = 0; i < D; i++) begin slot_code[i] = 4'h0; slot_err[i] = 1'b0; end
      m_mask = '0; done_pend = 0; cap_pend = 0;
      run_sel = '0; run_seg = '0; run_len = 0;
      s1_sel = '0; s2_sel = '0; s1_seg = '0; s2_seg = '0;
    end else begin
      m_xs = dig_sel;
      m_xg = seg_in;
`ifdef SEG7_READER_SYNC_EN
      m_xs = s2_sel; m_xg = s2_seg;
      s2_sel = s1_sel; s2_seg = s1_seg;
      s1_sel = dig_sel; s1_seg = seg_in;
`endif
      // output stage: a frame completed on the previous edge
      exp_overrun = 1'b0;
      if (done_pend) begin
        done_pend = 1'b0;
        if (!exp_valid || frame_ready) begin
          for (int i = 0; i < D; i++) begin
            exp_data[4*i +: 4] = slot_code[i];
            exp_err[i] = slot_err[i];
          end
          exp_valid = 1'b1;
        end else begin
          exp_overrun = 1'b1;
        end
      end else if (exp_valid && frame_ready) begin
        exp_valid = 1'b0;
      end
      // capture decided on the previous edge lands now
      if (cap_pend) begin
        cap_pend = 1'b0;
        slot_code[cap_idx] = cap_code;
        slot_err[cap_idx]  = cap_err;
        m_mask[cap_idx] = 1'b1;
        if (&m_mask) begin
          m_mask = '0;
          done_pend = 1'b1;
        end
      end
      // run length of identical samples
      if (m_xs == run_sel && m_xg == run_seg) begin
        if (run_len < 1000) run_len++;
      end else begin
        run_sel = m_xs; run_seg = m_xg; run_len = 1;
      end
      if (run_len == S && $countones(m_xs) == 1) begin
        cap_pend = 1'b1;
        for (int i = 0; i < D; i++) if (m_xs[i]) cap_idx = i;
        decode(m_xg, cap_code, cap_err);
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  logic prev_valid = 1'b0;
  int rises = 0, rise_cyc = 0, ovr_cnt = 0;
  logic [4*D-1:0] rise_data;
  logic [D-1:0]   rise_err;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_data", 32'(frame_data), 32'h0);
      check("rst_err", 32'(frame_err), 32'h0);
      check("rst_valid", 32'(frame_valid), 32'h0);
      check("rst_overrun", 32'(overrun), 32'h0);
    end else begin
      check("frame_data", 32'(frame_data), 32'(exp_data));
      check("frame_err", 32'(frame_err), 32'(exp_err));
      check("frame_valid", 32'(frame_valid), 32'(exp_valid));
      check("overrun", 32'(overrun), 32'(exp_overrun));
    end
    if (frame_valid && !prev_valid) begin
      rises++;
      rise_cyc  = cyc;
      rise_data = frame_data;
      rise_err  = frame_err;
    end
    prev_valid = frame_valid;
    if (overrun) ovr_cnt++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic show(input int d, input logic [6:0] p, input int n);
    logic [D-1:0] one;
    one = 4'b0001;
    dig_sel = one << d;
    seg_in  = p;
    tick(n);
  endtask

  task automatic blank(input int n);
    dig_sel = '0;
    seg_in  = 7'd0;
    tick(n);
  endtask

  // four digits held 6 cycles each; returns edge index k of the last digit
  task automatic frame(input int c0, input int c1, input int c2, input int c3, output int k);
    show(0, pats[c0], 6);
    show(1, pats[c1], 6);
    show(2, pats[c2], 6);
    k = cyc + 1;
    show(3, pats[c3], 6);
  endtask

  int k, r0, o0;

  initial begin
    tick(1);
    tick(3);
    rst = 1'b0;
    blank(3);

    // full frame and latency
    r0 = rises;
    frame(1, 2, 3, 4, k);
    blank(5);
    check("full_rises", 32'(rises - r0), 32'd1);
    check("full_latency", 32'(rise_cyc - k), 32'(LAT));
    check("full_data", 32'(rise_data), 32'h4321);
    check("full_err", 32'(rise_err), 32'h0);
    check("full_valid_fell", 32'(frame_valid), 32'h0);

    // glitch rejection on digit 2
    r0 = rises;
    show(0, pats[1], 6);
    show(2, pats[5], 6);
    show(1, pats[2], 6);
    show(2, pats[9], 3);
    show(3, pats[4], 6);
    blank(5);
    check("glitch_rises", 32'(rises - r0), 32'd1);
    check("glitch_data", 32'(rise_data), 32'h4521);

    // invalid and blank patterns
    r0 = rises;
    show(0, pats[7], 6);
    show(1, 7'b0000001, 6);
    show(2, pats[8], 6);
    show(3, 7'b0000000, 6);
    blank(5);
    check("inv_rises", 32'(rises - r0), 32'd1);
    check("inv_data", 32'(rise_data), 32'hF8E7);
    check("inv_err", 32'(rise_err), 32'b0010);

    // backpressure across two frames
    frame_ready = 1'b0;
    o0 = ovr_cnt;
    frame(9, 8, 7, 6, k);
    frame(0, 1, 2, 3, k);
    blank(5);
    check("bp_overruns", 32'(ovr_cnt - o0), 32'd1);
    check("bp_valid", 32'(frame_valid), 32'd1);
    check("bp_data", 32'(frame_data), 32'h6789);
    frame_ready = 1'b1;
    tick(1);
    check("bp_consumed", 32'(frame_valid), 32'd0);
    blank(2);

    // reset mid-frame
    show(0, pats[5], 6);
    show(1, pats[6], 6);
    rst = 1'b1;
    blank(2);
    rst = 1'b0;
    blank(1);
    r0 = rises;
    frame(2, 4, 6, 8, k);
    blank(6);
    check("rst_mid_rises", 32'(rises - r0), 32'd1);
    check("rst_mid_data", 32'(rise_data), 32'h8642);

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      int r;
      logic [D-1:0] one;
      one = 4'b0001;
      r = $urandom_range(0, 9);
      if (r < 8)       dig_sel = one << $urandom_range(0, D - 1);
      else if (r == 8) dig_sel = '0;
      else             dig_sel = D'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)       seg_in = pats[$urandom_range(0, 9)];
      else if (r == 7) seg_in = 7'd0;
      else             seg_in = 7'($urandom);
      frame_ready = ($urandom_range(0, 3) != 0);
      tick($urandom_range(1, 8));
    end
    frame_ready = 1'b1;
    blank(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
